// File: rtl/ace_line_fill.sv
// ace_line_fill
// ACE read-channel refill engine sitting between the cache controller and the
// interconnect. A miss request is turned into one line-sized INCR read on AR
// (ReadShared for read misses, ReadUnique for write misses). The R burst is
// collected into a line buffer. The line, IsShared/PassDirty and a sticky error
// flag are then presented to the datapath with a one-cycle fill_valid pulse,
// and RACK is pulsed in the same cycle. Only one transaction is in flight at a
// time.
//
// Ports
//   clk, rst_n       clock; synchronous active-low reset
//   req_valid/ready  controller fill request; req_addr (may be unaligned),
//                    req_unique (1 = ReadUnique)
//   fill_valid       1-cycle pulse qualifying fill_data/shared/dirty/err
//   fill_data        line data, beat k in [k*WIDTH_D +: WIDTH_D]
//   fill_shared/dirty  RRESP[3]/RRESP[2] of the finishing beat
//   fill_err         SLVERR/DECERR on any beat, or R_LAST on the wrong beat
//   AR_*             ACE read address channel (AR_ID is implicitly 0)
//   R_*, RRESP       ACE read data channel (R_ID ignored)
//   RACK             1-cycle read acknowledge
//   dbg_state        current FSM state (IDLE=0, ADDR=1, DATA=2, DONE=3)
//
// Handshakes: every channel is valid/ready. A transfer happens on a rising
// edge where both valid and ready are high. Once asserted, AR_VALID and all
// AR_* payload stay constant until that transfer. Ready may be high before
// valid.
module ace_line_fill #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_D = 32,
  parameter int BEATS   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH_A-1:0]       req_addr,
  input  logic                     req_unique,
  output logic                     fill_valid,
  output logic [BEATS*WIDTH_D-1:0] fill_data,
  output logic                     fill_shared,
  output logic                     fill_dirty,
  output logic                     fill_err,
  output logic                     AR_VALID,
  input  logic                     AR_READY,
  output logic [WIDTH_A-1:0]       AR_ADDR,
  output logic [7:0]               AR_LEN,
  output logic [2:0]               AR_SIZE,
  output logic [1:0]               AR_BURST,
  output logic [1:0]               AR_DOMAIN,
  output logic [3:0]               AR_SNOOP,
  input  logic                     R_VALID,
  output logic                     R_READY,
  input  logic [WIDTH_D-1:0]       R_DATA,
  input  logic [3:0]               RRESP,
  input  logic                     R_LAST,
  output logic                     RACK,
  output logic [1:0]               dbg_state
);

  localparam int BEAT_W = $clog2(BEATS);
  // Byte-offset bits inside one cache line; cleared to line-align AR_ADDR.
  localparam int OFF_W  = $clog2(BEATS * WIDTH_D / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                         state_q;
  state_t                         state_d;
  logic [WIDTH_A-1:0]             addr_q;
  logic [3:0]                     snoop_q;
  logic [BEAT_W-1:0]              beat_cnt_q;
  logic [BEATS-1:0][WIDTH_D-1:0]  line_q;
  logic                           shared_q;
  logic                           dirty_q;
  logic                           err_q;

  logic req_accept;
  logic beat_accept;
  logic last_slot;
  logic beat_final;
  logic unused_rresp;

  assign req_accept  = (state_q == IDLE) && req_valid;
  assign beat_accept = (state_q == DATA) && R_VALID;
  assign last_slot   = (beat_cnt_q == BEAT_W'(BEATS - 1));
  // The burst ends on R_LAST or when the line buffer is full, whichever is
  // first. Beats after a missing R_LAST are left on the bus, not consumed.
  assign beat_final  = beat_accept && (R_LAST || last_slot);

  // RRESP[0] only separates OKAY from EXOKAY (and SLVERR from DECERR), which
  // makes no difference here.
  assign unused_rresp = RRESP[0];

  // Fixed burst shape: one full line, INCR, inner shareable.
  assign AR_ADDR   = addr_q;
  assign AR_LEN    = 8'(BEATS - 1);
  assign AR_SIZE   = 3'($clog2(WIDTH_D / 8));
  assign AR_BURST  = 2'b01;
  assign AR_DOMAIN = 2'b01;
  assign AR_SNOOP  = snoop_q;

  assign fill_data   = line_q;
  assign fill_shared = shared_q;
  assign fill_dirty  = dirty_q;
  assign fill_err    = err_q;
  assign dbg_state   = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    AR_VALID   = 1'b0;
    R_READY    = 1'b0;
    fill_valid = 1'b0;
    RACK       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ADDR;
      end
      ADDR: begin
        AR_VALID = 1'b1;
        if (AR_READY) state_d = DATA;
      end
      DATA: begin
        R_READY = 1'b1;
        if (beat_final) state_d = DONE;
      end
      DONE: begin
        fill_valid = 1'b1;
        RACK       = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      snoop_q    <= '0;
      beat_cnt_q <= '0;
      line_q     <= '0;
      shared_q   <= 1'b0;
      dirty_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (req_accept) begin
        addr_q     <= {req_addr[WIDTH_A-1:OFF_W], {OFF_W{1'b0}}};
        snoop_q    <= req_unique ? 4'b0111 : 4'b0001;
        beat_cnt_q <= '0;
        // Start each fill from a clean line so a short burst never exposes
        // data left over from the previous fill.
        line_q     <= '0;
        shared_q   <= 1'b0;
        dirty_q    <= 1'b0;
        err_q      <= 1'b0;
      end
      if (beat_accept) begin
        line_q[beat_cnt_q] <= R_DATA;
        beat_cnt_q         <= beat_cnt_q + BEAT_W'(1);
        // Error is sticky: slave error on any beat, or R_LAST disagreeing
        // with the beat count (early, or missing on the last slot).
        if (RRESP[1] || (R_LAST != last_slot)) err_q <= 1'b1;
        if (beat_final) begin
          shared_q <= RRESP[3];
          dirty_q  <= RRESP[2];
        end
      end
      if (state_q == DONE) beat_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_ace_line_fill.sv
// Bench for ace_line_fill: directed cases plus randomized fills. Each fill
// pushes its expected AR beat and expected line/flags into queues. Monitors
// pop and compare whenever the DUT presents an AR handshake or a fill_valid
// pulse.
module tb_ace_line_fill;
  localparam int WA = 32;
  localparam int WD = 32;
  localparam int NB = 4;
  localparam int LW = NB * WD;
  localparam logic [WA-1:0] LINE_MASK = ~WA'(NB * WD / 8 - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [WA-1:0] req_addr = '0;
  logic          req_unique = 1'b0;
  logic          fill_valid;
  logic [LW-1:0] fill_data;
  logic          fill_shared;
  logic          fill_dirty;
  logic          fill_err;
  logic          AR_VALID;
  logic          AR_READY = 1'b0;
  logic [WA-1:0] AR_ADDR;
  logic [7:0]    AR_LEN;
  logic [2:0]    AR_SIZE;
  logic [1:0]    AR_BURST;
  logic [1:0]    AR_DOMAIN;
  logic [3:0]    AR_SNOOP;
  logic          R_VALID = 1'b0;
  logic          R_READY;
  logic [WD-1:0] R_DATA = '0;
  logic [3:0]    RRESP = '0;
  logic          R_LAST = 1'b0;
  logic          RACK;
  logic [1:0]    dbg_state;

  ace_line_fill #(.WIDTH_A(WA), .WIDTH_D(WD), .BEATS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_unique(req_unique),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_shared(fill_shared),
    .fill_dirty(fill_dirty), .fill_err(fill_err),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .AR_LEN(AR_LEN), .AR_SIZE(AR_SIZE), .AR_BURST(AR_BURST),
    .AR_DOMAIN(AR_DOMAIN), .AR_SNOOP(AR_SNOOP),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .RRESP(RRESP),
    .R_LAST(R_LAST), .RACK(RACK), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [WA+3:0] exp_ar_q[$];    // {line address, snoop}
  logic [LW+2:0] exp_fill_q[$];  // {line, shared, dirty, err}

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  logic          prev_fill = 1'b0;
  logic          prev_ar_stall = 1'b0;
  logic          prev_ar_hs = 1'b0;
  logic [WA-1:0] prev_ar_addr = '0;
  logic [3:0]    prev_ar_snoop = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_fill = 1'b0;
      prev_ar_stall = 1'b0;
      prev_ar_hs = 1'b0;
    end else begin
      if (fill_valid) begin
        logic [LW+2:0] e;
        chk("fill_pulse_width", LW'(prev_fill), 0);
        chk("rack_with_fill", LW'(RACK), 1);
        chk("fill_expected", LW'(exp_fill_q.size() > 0), 1);
        if (exp_fill_q.size() > 0) begin
          e = exp_fill_q.pop_front();
          chk("fill_data", fill_data, e[LW+2:3]);
          chk("fill_shared", LW'(fill_shared), LW'(e[2]));
          chk("fill_dirty", LW'(fill_dirty), LW'(e[1]));
          chk("fill_err", LW'(fill_err), LW'(e[0]));
        end
      end else if (RACK) begin
        chk("rack_without_fill", LW'(RACK), 0);
      end
      prev_fill = fill_valid;

      if (AR_VALID) begin
        if (prev_ar_hs) chk("ar_valid_drop", LW'(AR_VALID), 0);
        if (prev_ar_stall) begin
          chk("ar_addr_stable", LW'(AR_ADDR), LW'(prev_ar_addr));
          chk("ar_snoop_stable", LW'(AR_SNOOP), LW'(prev_ar_snoop));
        end
        if (AR_READY) begin
          logic [WA+3:0] e;
          chk("ar_expected", LW'(exp_ar_q.size() > 0), 1);
          if (exp_ar_q.size() > 0) begin
            e = exp_ar_q.pop_front();
            chk("ar_addr", LW'(AR_ADDR), LW'(e[WA+3:4]));
            chk("ar_snoop", LW'(AR_SNOOP), LW'(e[3:0]));
          end
          chk("ar_len", LW'(AR_LEN), NB - 1);
          chk("ar_size", LW'(AR_SIZE), 2);
          chk("ar_burst", LW'(AR_BURST), 1);
          chk("ar_domain", LW'(AR_DOMAIN), 1);
        end
      end
      prev_ar_stall = AR_VALID && !AR_READY;
      prev_ar_hs    = AR_VALID && AR_READY;
      prev_ar_addr  = AR_ADDR;
      prev_ar_snoop = AR_SNOOP;
    end
  end

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic [WA-1:0] addr, input bit uniq);
    int n = 0;
    req_valid = 1'b1;
    req_addr = addr;
    req_unique = uniq;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", LW'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    req_addr = $urandom;
  endtask

  task automatic ar_slave(input int delay);
    int n = 0;
    AR_READY = 1'b0;
    repeat (delay) tick();
    AR_READY = 1'b1;
    @(negedge clk);
    while (!AR_VALID && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!AR_VALID) chk("ar_valid_timeout", LW'(AR_VALID), 1);
    tick();
    AR_READY = 1'b0;
  endtask

  task automatic send_beat(input logic [WD-1:0] d, input logic [3:0] resp, input bit last);
    int n = 0;
    R_VALID = 1'b1;
    R_DATA = d;
    RRESP = resp;
    R_LAST = last;
    @(negedge clk);
    while (!R_READY && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!R_READY) chk("r_ready_timeout", LW'(R_READY), 1);
    tick();
    R_VALID = 1'b0;
    R_LAST = 1'b0;
    RRESP = $urandom;
    R_DATA = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("idle_timeout", LW'(req_ready), 1);
    tick();
  endtask

  // One complete fill. last_pos: index of the beat carrying R_LAST (-1 = never).
  // err_beat: index of a beat with SLVERR/DECERR (-1 = none). gap < 0 = random.
  task automatic do_fill(input logic [WA-1:0] addr, input bit uniq, input int last_pos,
                         input int ar_delay, input int gap, input int err_beat,
                         input logic [1:0] fin_flags, input bit stray);
    logic [WD-1:0] data[NB];
    logic [LW-1:0] line;
    logic          err;
    int            nsend;
    nsend = (last_pos >= 0 && last_pos < NB - 1) ? last_pos + 1 : NB;
    line = '0;
    for (int b = 0; b < NB; b++) begin
      data[b] = $urandom;
      if (b < nsend) line[b*WD +: WD] = data[b];
    end
    err = (last_pos != NB - 1) || (err_beat >= 0 && err_beat < nsend);
    exp_ar_q.push_back({addr & LINE_MASK, uniq ? 4'b0111 : 4'b0001});
    exp_fill_q.push_back({line, fin_flags, err});

    issue_req(addr, uniq);
    ar_slave(ar_delay);
    for (int b = 0; b < nsend; b++) begin
      int g;
      logic [1:0] hi;
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      repeat (g) tick();
      hi = (b == nsend - 1) ? fin_flags : 2'($urandom_range(0, 3));
      send_beat(data[b], {hi, (b == err_beat), 1'($urandom_range(0, 1))}, b == last_pos);
      if (b == nsend - 1) chk("fill_latency", LW'(fill_valid), 1);
    end
    if (stray) begin
      R_VALID = 1'b1;
      R_DATA = $urandom;
      repeat (3) begin
        @(negedge clk);
        chk("stray_not_consumed", LW'(R_READY), 0);
        tick();
      end
      R_VALID = 1'b0;
    end
    wait_idle();
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", LW'(req_ready), 1);
    chk("rst_ar_valid", LW'(AR_VALID), 0);
    chk("rst_r_ready", LW'(R_READY), 0);
    chk("rst_fill_valid", LW'(fill_valid), 0);
    chk("rst_rack", LW'(RACK), 0);
    chk("rst_fill_data", fill_data, 0);
    chk("rst_fill_err", LW'(fill_err), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst_n = 1'b1;
    tick();

    // ReadShared, unaligned address, IsShared on last beat.
    do_fill(32'h0000_1004, 1'b0, NB - 1, 0, 0, -1, 2'b10, 1'b0);
    // ReadUnique with AR_READY held low 3 cycles, PassDirty on last beat.
    do_fill($urandom, 1'b1, NB - 1, 3, 0, -1, 2'b01, 1'b0);
    // Two idle cycles between beats.
    do_fill($urandom, 1'b0, NB - 1, 1, 2, -1, 2'b00, 1'b0);
    // SLVERR on beat 1.
    do_fill($urandom, 1'b0, NB - 1, 0, 0, 1, 2'b11, 1'b0);
    // Early R_LAST on beat 1, then a normal fill.
    do_fill($urandom, 1'b1, 1, 0, 0, -1, 2'b10, 1'b0);
    do_fill($urandom, 1'b0, NB - 1, 0, 0, -1, 2'b00, 1'b0);
    // R_LAST missing on the last slot; the extra beat must be left alone.
    do_fill($urandom, 1'b0, -1, 2, 1, -1, 2'b01, 1'b1);

    // Reset in the middle of the data phase: no fill, no RACK.
    exp_ar_q.push_back({32'h0000_2A3C & LINE_MASK, 4'b0001});
    issue_req(32'h0000_2A3C, 1'b0);
    ar_slave(0);
    send_beat($urandom, 4'b0000, 1'b0);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_fill", LW'(fill_valid), 0);
      tick();
    end
    do_fill($urandom, 1'b1, NB - 1, 0, 0, -1, 2'b11, 1'b0);

    // Randomized fills.
    for (int i = 0; i < 40; i++) begin
      int kind;
      int lp;
      int eb;
      kind = $urandom_range(0, 9);
      lp = (kind == 0) ? $urandom_range(0, NB - 2) : (kind == 1) ? -1 : NB - 1;
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NB - 1) : -1;
      do_fill($urandom, 1'($urandom_range(0, 1)), lp, $urandom_range(0, 3), -1, eb,
              2'($urandom_range(0, 3)), (kind == 1) && ($urandom_range(0, 1) == 1));
    end

    repeat (5) tick();
    chk("ar_queue_drained", LW'(exp_ar_q.size()), 0);
    chk("fill_queue_drained", LW'(exp_fill_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
